pipe_ctrl: RTL and testbench

//  Central pipeline sequencer for the 5-stage core. Each cycle it drives the ctrl_signal of the IF_ID, ID_EX, EX_MEM and MEM_WB

---
 rtl/pipe_ctrl_pkg.sv | 50 +++++
 rtl/pipe_ctrl_if.sv | 36 +++
 rtl/pipe_ctrl_sat_counter.sv | 23 ++
 rtl/pipe_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: per-register control, PC select and FSM states.
// The control encoding is what every pipeline register decodes.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      CtrlDefault = 2'b00,
      CtrlStall   = 2'b01,
      CtrlFlush   = 2'b10
   } ctrl_e;

   typedef enum logic [1:0] {
      PcSeq    = 2'b00,
      PcHold   = 2'b01,
      PcBranch = 2'b10,
      PcTrap   = 2'b11
   } pc_sel_e;

   typedef enum logic [1:0] {
      StRun     = 2'b00,
      StMemWait = 2'b01,
      StTrap    = 2'b10
   } state_e;

   typedef struct packed {
      ctrl_e   if_id;
      ctrl_e   id_ex;
      ctrl_e   ex_mem;
      ctrl_e   mem_wb;
      pc_sel_e pc_sel;
   } pipe_cmd_t;

   function automatic pipe_cmd_t cmd_all(input ctrl_e c, input pc_sel_e pc);
      pipe_cmd_t cmd;
      cmd.if_id  = c;
      cmd.id_ex  = c;
      cmd.ex_mem = c;
      cmd.mem_wb = c;
      cmd.pc_sel = pc;
      return cmd;
   endfunction

   // Front of the pipe holds while the outstanding access drains a bubble into MEM_WB.
   function automatic pipe_cmd_t cmd_mem_stall();
      pipe_cmd_t cmd;
      cmd        = cmd_all(CtrlStall, PcHold);
      cmd.mem_wb = CtrlFlush;
      return cmd;
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline stages and the sequencer.
// master = sequencer side, slave = pipeline side.
interface pipe_ctrl_if
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) ();

   logic             id_stall_req_i;
   logic             ex_stall_req_i;
   logic             ex_branch_i;
   logic             mem_req_i;
   logic             mem_ready_i;
   logic             trap_req_i;
   logic             trap_ack_o;
   logic             mem_abort_o;
   ctrl_e            ctrl_if_id_o;
   ctrl_e            ctrl_id_ex_o;
   ctrl_e            ctrl_ex_mem_o;
   ctrl_e            ctrl_mem_wb_o;
   logic [1:0]       pc_sel_o;
   logic [CNT_W-1:0] stall_cnt_o;

   modport master (
      input  id_stall_req_i, ex_stall_req_i, ex_branch_i, mem_req_i, mem_ready_i, trap_req_i,
      output trap_ack_o, mem_abort_o, ctrl_if_id_o, ctrl_id_ex_o, ctrl_ex_mem_o, ctrl_mem_wb_o,
             pc_sel_o, stall_cnt_o
   );

   modport slave (
      output id_stall_req_i, ex_stall_req_i, ex_branch_i, mem_req_i, mem_ready_i, trap_req_i,
      input  trap_ack_o, mem_abort_o, ctrl_if_id_o, ctrl_id_ex_o, ctrl_ex_mem_o, ctrl_mem_wb_o,
             pc_sel_o, stall_cnt_o
   );

endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module pipe_ctrl_sat_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: arbitrates hazard, memory-wait, branch and trap requests into per-register
// Default/Stall/Flush controls and a PC select, with a memory watchdog and a stall-cycle counter.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 256,
   parameter int unsigned TRAP_BUBBLE = 1,
   parameter int unsigned CNT_W       = 32
) (
   input logic         clk,
   input logic         rst,
   pipe_ctrl_if.master bus
);

   localparam int unsigned WaitW = $clog2(MEM_TIMEOUT);
   localparam int unsigned BubW  = (TRAP_BUBBLE > 1) ? $clog2(TRAP_BUBBLE) : 1;
   localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);
   localparam logic [BubW-1:0]  BubLast  = BubW'(TRAP_BUBBLE - 1);

   state_e            state_q, state_d;
   logic [WaitW-1:0]  wait_q, wait_d;
   logic [BubW-1:0]   bub_q, bub_d;
   pipe_cmd_t         run_cmd, cmd;
   logic              mem_stall;
   logic              wait_expired;
   logic              trap_ack, mem_abort;
   logic              any_stall;

   assign mem_stall    = bus.mem_req_i & ~bus.mem_ready_i;
   assign wait_expired = (wait_q == WaitLast);

   // Run-state priority decode; also used on the cycle a memory wait completes.
   always_comb begin
      run_cmd = cmd_all(CtrlDefault, PcSeq);
      if (bus.trap_req_i) begin
         run_cmd = cmd_all(CtrlFlush, PcTrap);
      end else if (mem_stall) begin
         run_cmd = cmd_mem_stall();
      end else if (bus.ex_stall_req_i) begin
         run_cmd.if_id  = CtrlStall;
         run_cmd.id_ex  = CtrlStall;
         run_cmd.ex_mem = CtrlFlush;
         run_cmd.pc_sel = PcHold;
      end else if (bus.ex_branch_i) begin
         run_cmd.if_id  = CtrlFlush;
         run_cmd.id_ex  = CtrlFlush;
         run_cmd.pc_sel = PcBranch;
      end else if (bus.id_stall_req_i) begin
         run_cmd.if_id  = CtrlStall;
         run_cmd.id_ex  = CtrlFlush;
         run_cmd.pc_sel = PcHold;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StRun;
         wait_q  <= '0;
         bub_q   <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         bub_q   <= bub_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      bub_d   = bub_q;
      unique case (state_q)
         StRun: begin
            if (bus.trap_req_i) begin
               state_d = StTrap;
               bub_d   = '0;
            end else if (mem_stall) begin
               state_d = StMemWait;
               wait_d  = WaitW'(1);
            end
         end
         StMemWait: begin
            if (bus.mem_ready_i) begin
               state_d = bus.trap_req_i ? StTrap : StRun;
               bub_d   = '0;
            end else if (wait_expired) begin
               state_d = StTrap;
               bub_d   = '0;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         StTrap: begin
            if (bub_q == BubLast) begin
               state_d = StRun;
            end else begin
               bub_d = bub_q + 1'b1;
            end
         end
         default: state_d = StRun;
      endcase
   end

   always_comb begin
      cmd       = cmd_all(CtrlDefault, PcSeq);
      trap_ack  = 1'b0;
      mem_abort = 1'b0;
      if (!rst) begin
         unique case (state_q)
            StRun: begin
               cmd      = run_cmd;
               trap_ack = bus.trap_req_i;
            end
            StMemWait: begin
               if (bus.mem_ready_i) begin
                  cmd      = run_cmd;
                  trap_ack = bus.trap_req_i;
               end else if (wait_expired) begin
                  cmd       = cmd_all(CtrlFlush, PcTrap);
                  mem_abort = 1'b1;
               end else begin
                  cmd = cmd_mem_stall();
               end
            end
            StTrap:  cmd.if_id = CtrlFlush;
            default: cmd = cmd_all(CtrlDefault, PcSeq);
         endcase
      end
   end

   assign any_stall = (cmd.if_id == CtrlStall) || (cmd.id_ex == CtrlStall) ||
                      (cmd.ex_mem == CtrlStall) || (cmd.mem_wb == CtrlStall);

   pipe_ctrl_sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (any_stall),
      .cnt_o (bus.stall_cnt_o)
   );

   assign bus.ctrl_if_id_o  = cmd.if_id;
   assign bus.ctrl_id_ex_o  = cmd.id_ex;
   assign bus.ctrl_ex_mem_o = cmd.ex_mem;
   assign bus.ctrl_mem_wb_o = cmd.mem_wb;
   assign bus.pc_sel_o      = cmd.pc_sel;
   assign bus.trap_ack_o    = trap_ack;
   assign bus.mem_abort_o   = mem_abort;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic against a
// cycle-level reference model of the sequencing rules.
module tb_pipe_ctrl;
   import pipe_ctrl_pkg::*;

   localparam int unsigned MemTimeout = 4;
   localparam int unsigned TrapBubble = 2;
   localparam int unsigned CntW       = 4;
   localparam int          CntMax     = (1 << CntW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   pipe_ctrl_if #(.CNT_W(CntW)) bus ();

   pipe_ctrl #(
      .MEM_TIMEOUT (MemTimeout),
      .TRAP_BUBBLE (TrapBubble),
      .CNT_W       (CntW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   task automatic check_eq(input string tag, input int obs, input int exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: how long the memory has been stalled, how many bubbles remain.
   bit         waiting;
   int         waited;
   int         bubbles_left;
   int         stalls;
   ctrl_e      exp_ctrl[4];
   int         exp_pc;
   bit         exp_ack;
   bit         exp_abort;

   task automatic set_all(input ctrl_e c, input int pc);
      for (int i = 0; i < 4; i++) exp_ctrl[i] = c;
      exp_pc = pc;
   endtask

   task automatic predict(input bit r, input bit idr, input bit exr, input bit br,
                          input bit mreq, input bit mrdy, input bit trap);
      bit any_stall;
      set_all(CtrlDefault, 0);
      exp_ack   = 1'b0;
      exp_abort = 1'b0;
      if (r) begin
         waiting      = 1'b0;
         waited       = 0;
         bubbles_left = 0;
         stalls       = 0;
         return;
      end
      if (bubbles_left > 0) begin
         exp_ctrl[0] = CtrlFlush;
         bubbles_left--;
      end else if (waiting && !mrdy) begin
         if (waited + 1 == MemTimeout) begin
            set_all(CtrlFlush, 3);
            exp_abort    = 1'b1;
            waiting      = 1'b0;
            bubbles_left = TrapBubble;
         end else begin
            set_all(CtrlStall, 1);
            exp_ctrl[3] = CtrlFlush;
            waited++;
         end
      end else begin
         waiting = 1'b0;
         if (trap) begin
            set_all(CtrlFlush, 3);
            exp_ack      = 1'b1;
            bubbles_left = TrapBubble;
         end else if (mreq && !mrdy) begin
            set_all(CtrlStall, 1);
            exp_ctrl[3] = CtrlFlush;
            waiting     = 1'b1;
            waited      = 1;
         end else if (exr) begin
            exp_ctrl[0] = CtrlStall;
            exp_ctrl[1] = CtrlStall;
            exp_ctrl[2] = CtrlFlush;
            exp_pc      = 1;
         end else if (br) begin
            exp_ctrl[0] = CtrlFlush;
            exp_ctrl[1] = CtrlFlush;
            exp_pc      = 2;
         end else if (idr) begin
            exp_ctrl[0] = CtrlStall;
            exp_ctrl[1] = CtrlFlush;
            exp_pc      = 1;
         end
      end
      any_stall = 1'b0;
      for (int i = 0; i < 4; i++) if (exp_ctrl[i] == CtrlStall) any_stall = 1'b1;
      if (any_stall && stalls < CntMax) stalls++;
   endtask

   task automatic step(input bit r, input bit idr, input bit exr, input bit br,
                       input bit mreq, input bit mrdy, input bit trap);
      @(negedge clk);
      rst                = r;
      bus.id_stall_req_i = idr;
      bus.ex_stall_req_i = exr;
      bus.ex_branch_i    = br;
      bus.mem_req_i      = mreq;
      bus.mem_ready_i    = mrdy;
      bus.trap_req_i     = trap;
      #1;
      predict(r, idr, exr, br, mreq, mrdy, trap);
      check_eq("ctrl_if_id", int'(bus.ctrl_if_id_o), int'(exp_ctrl[0]));
      check_eq("ctrl_id_ex", int'(bus.ctrl_id_ex_o), int'(exp_ctrl[1]));
      check_eq("ctrl_ex_mem", int'(bus.ctrl_ex_mem_o), int'(exp_ctrl[2]));
      check_eq("ctrl_mem_wb", int'(bus.ctrl_mem_wb_o), int'(exp_ctrl[3]));
      check_eq("pc_sel", int'(bus.pc_sel_o), exp_pc);
      check_eq("trap_ack", int'(bus.trap_ack_o), int'(exp_ack));
      check_eq("mem_abort", int'(bus.mem_abort_o), int'(exp_abort));
      @(posedge clk);
      #1;
      check_eq("stall_cnt", int'(bus.stall_cnt_o), stalls);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      bit trap_hold;
      bit mem_hold;
      bit r, idr, exr, br, mreq, mrdy, trap;

      bus.id_stall_req_i = 1'b0;
      bus.ex_stall_req_i = 1'b0;
      bus.ex_branch_i    = 1'b0;
      bus.mem_req_i      = 1'b0;
      bus.mem_ready_i    = 1'b0;
      bus.trap_req_i     = 1'b0;

      // Idle pipe.
      do_reset();
      idle(10);
      check_eq("idle_stall_cnt", int'(bus.stall_cnt_o), 0);

      // Memory wait of three cycles, then ready.
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 1, 0);
      check_eq("memwait_stall_cnt", int'(bus.stall_cnt_o), 3);
      idle(2);

      // Watchdog expiry, trap bubbles, back to run.
      do_reset();
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      check_eq("abort_pulse_seen", int'(exp_abort), 1);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0);

      // Branch beats load-use; multi-cycle EX beats branch.
      step(0, 1, 0, 1, 0, 0, 0);
      step(0, 1, 1, 1, 0, 0, 0);
      idle(1);

      // Trap pending during memory wait is taken on the ready cycle.
      do_reset();
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0, 1);
      step(0, 0, 0, 0, 1, 0, 1);
      step(0, 0, 0, 0, 1, 1, 1);
      idle(3);

      // Saturation, then reset in the middle of a memory wait.
      do_reset();
      for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 0, 0, 0);
      check_eq("sat_stall_cnt", int'(bus.stall_cnt_o), CntMax);
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 1, 0, 0);
      check_eq("rst_mid_wait_cnt", int'(bus.stall_cnt_o), 0);
      idle(3);

      // Randomized traffic; trap and memory requests held by their sources until served.
      trap_hold = 1'b0;
      mem_hold  = 1'b0;
      for (int n = 0; n < 600; n++) begin
         r    = ($urandom_range(0, 79) == 0);
         idr  = ($urandom_range(0, 3) == 0);
         exr  = ($urandom_range(0, 4) == 0);
         br   = ($urandom_range(0, 3) == 0);
         mreq = mem_hold | ($urandom_range(0, 5) == 0);
         mrdy = ($urandom_range(0, 2) == 0);
         trap = trap_hold | ($urandom_range(0, 19) == 0);
         step(r, idr, exr, br, mreq, mrdy, trap);
         trap_hold = trap && !exp_ack && !r;
         mem_hold  = mreq && !mrdy && !r && !exp_abort;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
